// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths, quadrant codes, LFSR constants and slot helper for the serial NCO
package nco_pkg;

   localparam int ACC_W_DEF   = 20;
   localparam int ADDR_W_DEF  = 12;
   localparam int SLICE_W_DEF = 2;

   // Quadrant is the top two phase bits.
   typedef enum logic [1:0] {
      Q1 = 2'b00,
      Q2 = 2'b01,
      Q3 = 2'b10,
      Q4 = 2'b11
   } quad_e;

   // Prefixes placed above the folded fraction for the remapped quadrants.
   localparam logic [1:0] FOLD_Q2_HI = 2'b11;
   localparam logic [1:0] FOLD_Q3_HI = 2'b00;

   // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1.
   localparam int          LFSR_W    = 16;
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic int nslot(input int addr_w, input int slice_w);
      return addr_w / slice_w;
   endfunction

endpackage

// File: rtl/nco_phase_fold.sv
// rtl/nco_phase_fold.sv - combinational quadrant fold of a phase word into ROM address plus invert flag
//
// Ports:
//   phase  in   ACC_W   dithered/offset phase word
//   addr   out  ADDR_W  folded address (2 quadrant bits + fraction)
//   inv    out  1       sign-invert flag (quadrants 2 and 3)
module nco_phase_fold
   import nco_pkg::*;
#(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ACC_W-1:0]  phase,
   output logic [ADDR_W-1:0] addr,
   output logic              inv
);

   quad_e             q;
   logic [ADDR_W-3:0] f;
   logic              unused_phase;

   assign q = quad_e'(phase[ACC_W-1 -: 2]);
   assign f = phase[ACC_W-3 -: ADDR_W-2];

   // Bits below the address field are truncated away.
   assign unused_phase = &{1'b0, phase};

   always_comb begin
      addr = phase[ACC_W-1 -: ADDR_W];
      case (q)
         Q2:      addr = {FOLD_Q2_HI, f};
         Q3:      addr = {FOLD_Q3_HI, f};
         default: addr = phase[ACC_W-1 -: ADDR_W];
      endcase
   end

   assign inv = phase[ACC_W-1] ^ phase[ACC_W-2];

endmodule

// File: rtl/phase_accumulator_ser.sv
// rtl/phase_accumulator_ser.sv - frame-based NCO phase accumulator with serial folded-address output
//
// Optional build macro: PHASE_DITHER_EN adds a 16-bit LFSR dither into the sampled phase.
//
// Ports:
//   clk      in   1        clock
//   rst_n    in   1        synchronous active-low reset
//   En       in   1        run enable; low pauses without losing state
//   FCW      in   ACC_W    new frequency control word
//   FCW_ld   in   1        strobe: capture FCW into shadow
//   FCW_ack  out  1        pulse: shadow FCW has been applied
//   PHS      in   ACC_W    phase offset, sampled at each frame boundary
//   Vld      out  1        frame-boundary strobe
//   Aout     out  SLICE_W  serial address slice, LSB slice first
//   ISout    out  1        sign-invert flag for the current frame
module phase_accumulator_ser
   import nco_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               En,
   input  logic [ACC_W-1:0]   FCW,
   input  logic               FCW_ld,
   output logic               FCW_ack,
   input  logic [ACC_W-1:0]   PHS,
   output logic               Vld,
   output logic [SLICE_W-1:0] Aout,
   output logic               ISout
);

   localparam int NSLOT  = nslot(ADDR_W, SLICE_W);
   localparam int SLOT_W = $clog2(NSLOT + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NSLOT);
   localparam logic [SLOT_W-1:0] SLOT_RST  = SLOT_W'(NSLOT - 1);

   logic [SLOT_W-1:0] slot;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  fcw_act;
   logic [ACC_W-1:0]  shadow;
   logic              pending;
   logic [ADDR_W-1:0] addr;
   logic              is_q;
   logic              ack_q;

   logic              frame_end;
   logic [ACC_W-1:0]  dith;
   logic [ACC_W-1:0]  phase;
   logic [ADDR_W-1:0] addr_nxt;
   logic              is_nxt;

   assign frame_end = En && (slot == SLOT_LAST);

`ifdef PHASE_DITHER_EN
   localparam int DITH_W = ((ACC_W - ADDR_W) < LFSR_W) ? (ACC_W - ADDR_W) : LFSR_W;

   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (frame_end) begin
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
      end
   end

   // Only the sampled phase is dithered, never the accumulator.
   always_comb begin
      dith = '0;
      for (int i = 0; i < DITH_W; i++) begin
         dith[i] = lfsr[i];
      end
   end
`else
   assign dith = '0;
`endif

   assign phase = acc + PHS + dith;

   nco_phase_fold #(
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_fold (
      .phase (phase),
      .addr  (addr_nxt),
      .inv   (is_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot    <= SLOT_RST;
         acc     <= '0;
         fcw_act <= '0;
         shadow  <= '0;
         pending <= 1'b0;
         addr    <= '0;
         is_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         // ack_q is held while paused so the pulse is not lost across a pause.
         if (En) begin
            ack_q <= frame_end && pending;
            if (frame_end) begin
               slot <= '0;
               addr <= addr_nxt;
               is_q <= is_nxt;
               if (pending) begin
                  acc     <= acc + shadow;
                  fcw_act <= shadow;
                  pending <= 1'b0;
               end else begin
                  acc <= acc + fcw_act;
               end
            end else begin
               slot <= slot + SLOT_W'(1);
            end
         end
         // Placed last so a strobe coincident with the frame boundary re-arms pending.
         if (FCW_ld) begin
            shadow  <= FCW;
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      Aout = '0;
      if (En) begin
         for (int s = 0; s < NSLOT; s++) begin
            if (slot == SLOT_W'(s)) begin
               Aout = addr[s*SLICE_W +: SLICE_W];
            end
         end
      end
   end

   assign Vld     = frame_end;
   assign FCW_ack = ack_q && En;
   assign ISout   = is_q;

endmodule

// File: tb/tb_phase_accumulator_ser.sv
// tb/tb_phase_accumulator_ser.sv - self-checking bench with frame-level reference model for phase_accumulator_ser
module tb_phase_accumulator_ser;

   localparam int ACC_W   = 20;
   localparam int ADDR_W  = 12;
   localparam int SLICE_W = 2;
   localparam int NS      = 6;

   logic        clk = 1'b0;
   logic        rst_n, en, fcw_ld;
   logic [19:0] fcw, phs;
   logic        fcw_ack, vld, isout;
   logic [1:0]  aout;

   int total = 0;
   int bad   = 0;

   int          m_pos;
   logic [19:0] m_acc, m_fcw, m_sh;
   bit          m_pend, m_ackdue, m_is;
   logic [11:0] m_addr;

   logic       o_vld, o_ack, o_is, e_vld, e_ack, e_is;
   logic [1:0] o_aout, e_aout;
   int         ack_cnt = 0;

   always #5 clk = ~clk;

   phase_accumulator_ser #(
      .ACC_W   (ACC_W),
      .ADDR_W  (ADDR_W),
      .SLICE_W (SLICE_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .En      (en),
      .FCW     (fcw),
      .FCW_ld  (fcw_ld),
      .FCW_ack (fcw_ack),
      .PHS     (phs),
      .Vld     (vld),
      .Aout    (aout),
      .ISout   (isout)
   );

   function automatic logic [11:0] ref_addr(input logic [19:0] p);
      int pv, q, f;
      pv = int'(p);
      q  = pv / (1 << 18);
      f  = (pv % (1 << 18)) / (1 << 8);
      if (q == 1) return 12'(12'hC00 + f);
      if (q == 2) return 12'(f);
      return 12'(pv / 256);
   endfunction

   function automatic bit ref_inv(input logic [19:0] p);
      int q;
      q = int'(p) / (1 << 18);
      return (q == 1) || (q == 2);
   endfunction

   task automatic model_reset();
      m_pos = NS - 1; m_acc = '0; m_fcw = '0; m_sh = '0;
      m_pend = 0; m_ackdue = 0; m_is = 0; m_addr = '0;
   endtask

   // One clock: sample outputs, form model expectations, then advance the model at the edge.
   task automatic tick();
      logic [19:0] p;
      #1;
      o_vld = vld; o_ack = fcw_ack; o_is = isout; o_aout = aout;
      e_vld  = en && (m_pos == NS);
      e_aout = (en && m_pos < NS) ? 2'((m_addr >> (SLICE_W * m_pos)) & 12'h3) : 2'b00;
      e_is   = m_is;
      e_ack  = en && m_ackdue;
      if (o_ack === 1'b1) ack_cnt++;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (en) begin
            if (m_pos == NS) begin
               p = m_acc + phs;
               m_addr = ref_addr(p);
               m_is   = ref_inv(p);
               m_ackdue = m_pend;
               if (m_pend) begin
                  m_acc = m_acc + m_sh; m_fcw = m_sh; m_pend = 0;
               end else begin
                  m_acc = m_acc + m_fcw;
               end
               m_pos = 0;
            end else begin
               m_pos++;
               m_ackdue = 0;
            end
         end
         if (fcw_ld) begin
            m_sh = fcw; m_pend = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_vld(output int n, output bit ok);
      n = 0; ok = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         n++;
         if (o_vld === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic capture(output logic [11:0] a);
      a = '0;
      for (int s = 0; s < NS; s++) begin
         tick();
         a[s*SLICE_W +: SLICE_W] = o_aout;
      end
   endtask

   task automatic do_reset();
      rst_n = 0; en = 0; fcw_ld = 0; phs = '0; fcw = '0;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; en = 0; fcw_ld = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin en = 1; fcw_ld = 1; fcw = 20'h12345; end
         tick();
         total++;
         if (o_vld !== 1'b0 || o_aout !== 2'b00 || o_is !== 1'b0 || o_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: vld=%b aout=%b is=%b ack=%b required 0 00 0 0", o_vld, o_aout, o_is, o_ack);
         end
      end
      fcw_ld = 0; en = 0;
      tick();
   endtask

   task automatic test_first_frames();
      do_reset();
      en = 1; phs = '0; fcw = 20'h01000; fcw_ld = 1;
      for (int k = 0; k < 15; k++) begin
         tick();
         fcw_ld = 0;
         total++;
         if (o_vld !== 1'((k == 1) || (k == 8))) begin
            bad++; $display("FAIL first_vld: cycle %0d vld=%b", k, o_vld);
         end
         total++;
         if (o_ack !== 1'(k == 2)) begin
            bad++; $display("FAIL first_ack: cycle %0d ack=%b", k, o_ack);
         end
         total++;
         if (o_aout !== ((k == 11) ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL first_slices: cycle %0d aout=%b required %b", k, o_aout, (k == 11) ? 2'b01 : 2'b00);
         end
         total++;
         if (o_is !== 1'b0) begin
            bad++; $display("FAIL first_is: cycle %0d is=%b required 0", k, o_is);
         end
      end
   endtask

   task automatic test_quadrants();
      logic [19:0] ph_t [3] = '{20'h40000, 20'h80000, 20'hC0000};
      logic [11:0] ad_t [3] = '{12'hC00, 12'h000, 12'hC00};
      bit          is_t [3] = '{1'b1, 1'b1, 1'b0};
      logic [11:0] a;
      int n; bit ok;
      do_reset();
      en = 1;
      for (int i = 0; i < 3; i++) begin
         phs = ph_t[i];
         wait_vld(n, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL quad_timeout: entry %0d", i); end
         capture(a);
         total++;
         if (a !== ad_t[i]) begin
            bad++; $display("FAIL quad_addr: phs=%h addr=%h required %h", ph_t[i], a, ad_t[i]);
         end
         total++;
         if (o_is !== is_t[i]) begin
            bad++; $display("FAIL quad_is: phs=%h is=%b required %b", ph_t[i], o_is, is_t[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [11:0] a, ra;
      int n; bit ok;
      do_reset();
      en = 1; phs = '0; fcw = 20'h01000; fcw_ld = 1;
      tick();
      fcw_ld = 0;
      for (int f = 1; f <= 258; f++) begin
         wait_vld(n, ok);
         total++;
         if (!ok || (f > 1 && n != 1) || (f == 1 && n != 1)) begin
            bad++; $display("FAIL wrap_spacing: frame %0d gap=%0d required 7", f, n + NS);
         end
         capture(a);
         ra = ref_addr(20'((f - 1) * 32'h1000));
         if (f == 257) ra = 12'h000;
         if (f == 258) ra = 12'h010;
         total++;
         if (a !== ra) begin
            bad++; $display("FAIL wrap_addr: frame %0d addr=%h required %h", f, a, ra);
         end
      end
   endtask

   task automatic test_handshake();
      logic [11:0] a;
      int n, a0; bit ok;
      do_reset();
      en = 1; phs = '0;
      wait_vld(n, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL hs_timeout: no Vld"); end
      tick(); tick();
      fcw = 20'h02000; fcw_ld = 1; tick();
      fcw_ld = 0; tick();
      fcw = 20'h03000; fcw_ld = 1; tick();
      fcw_ld = 0; tick();
      a0 = ack_cnt;
      tick();
      total++;
      if (o_vld !== 1'b1 || o_ack !== 1'b0) begin
         bad++; $display("FAIL hs_vld_b: vld=%b ack=%b required 1 0", o_vld, o_ack);
      end
      capture(a);
      total++;
      if (a !== 12'h000) begin bad++; $display("FAIL hs_addr_b: addr=%h required 000", a); end
      total++;
      if (ack_cnt != a0 + 1) begin bad++; $display("FAIL hs_ack_single: acks=%0d required 1", ack_cnt - a0); end
      fcw = 20'h01000; fcw_ld = 1;
      tick();
      fcw_ld = 0;
      total++;
      if (o_vld !== 1'b1) begin bad++; $display("FAIL hs_vld_c: vld=%b required 1", o_vld); end
      capture(a);
      total++;
      if (a !== 12'h030) begin bad++; $display("FAIL hs_addr_c: addr=%h required 030", a); end
      total++;
      if (ack_cnt != a0 + 1) begin bad++; $display("FAIL hs_ack_coincident_early: acks=%0d required 1", ack_cnt - a0); end
      tick();
      capture(a);
      total++;
      if (a !== 12'h060) begin bad++; $display("FAIL hs_addr_d: addr=%h required 060", a); end
      total++;
      if (ack_cnt != a0 + 2) begin bad++; $display("FAIL hs_ack_coincident: acks=%0d required 2", ack_cnt - a0); end
      tick();
      capture(a);
      total++;
      if (a !== 12'h070) begin bad++; $display("FAIL hs_addr_e: addr=%h required 070", a); end
   endtask

   task automatic test_pause();
      logic [11:0] a;
      int n; bit ok;
      do_reset();
      en = 1; phs = '0; fcw = 20'h05000; fcw_ld = 1;
      tick();
      fcw_ld = 0;
      wait_vld(n, ok);
      wait_vld(n, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL pause_timeout: no Vld"); end
      a = '0;
      for (int s = 0; s < 3; s++) begin tick(); a[s*SLICE_W +: SLICE_W] = o_aout; end
      en = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin fcw = 20'h01000; fcw_ld = 1; end
         tick();
         fcw_ld = 0;
         total++;
         if (o_vld !== 1'b0 || o_aout !== 2'b00 || o_ack !== 1'b0) begin
            bad++; $display("FAIL pause_quiet: vld=%b aout=%b ack=%b required 0 00 0", o_vld, o_aout, o_ack);
         end
      end
      en = 1;
      for (int s = 3; s < NS; s++) begin tick(); a[s*SLICE_W +: SLICE_W] = o_aout; end
      total++;
      if (a !== 12'h050) begin bad++; $display("FAIL pause_resume_addr: addr=%h required 050", a); end
      tick();
      total++;
      if (o_vld !== 1'b1) begin bad++; $display("FAIL pause_vld: vld=%b required 1", o_vld); end
      capture(a);
      total++;
      if (a !== 12'h0A0) begin bad++; $display("FAIL pause_acc_held: addr=%h required 0A0", a); end
      tick();
      capture(a);
      total++;
      if (a !== 12'h0B0) begin bad++; $display("FAIL pause_ld_captured: addr=%h required 0B0", a); end
   endtask

   task automatic test_reset_mid();
      logic [11:0] a;
      int n, a0; bit ok;
      do_reset();
      en = 1; phs = 20'h40000; fcw = 20'h01000; fcw_ld = 1;
      tick();
      fcw_ld = 0;
      wait_vld(n, ok);
      tick(); tick(); tick();
      total++;
      if (o_is !== 1'b1) begin bad++; $display("FAIL rmid_pre_is: is=%b required 1", o_is); end
      rst_n = 0; fcw = 20'h07000; fcw_ld = 1;
      tick();
      rst_n = 1; fcw_ld = 0; phs = '0;
      a0 = ack_cnt;
      tick();
      total++;
      if (o_vld !== 1'b0 || o_aout !== 2'b00 || o_is !== 1'b0) begin
         bad++; $display("FAIL rmid_outputs: vld=%b aout=%b is=%b required 0 00 0", o_vld, o_aout, o_is);
      end
      for (int f = 0; f < 3; f++) begin
         wait_vld(n, ok);
         capture(a);
         total++;
         if (!ok || a !== 12'h000 || o_is !== 1'b0) begin
            bad++; $display("FAIL rmid_frame: frame %0d ok=%0d addr=%h is=%b required 000 0", f, ok, a, o_is);
         end
      end
      total++;
      if (ack_cnt != a0) begin bad++; $display("FAIL rmid_no_ack: acks=%0d required 0", ack_cnt - a0); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         rst_n  = ($urandom_range(0, 199) != 0);
         en     = ($urandom_range(0, 9) < 8);
         fcw_ld = ($urandom_range(0, 9) == 0);
         fcw    = 20'($urandom);
         phs    = 20'($urandom);
         tick();
         total++;
         if (o_vld !== e_vld) begin bad++; $display("FAIL rand_vld: cycle %0d vld=%b required %b", k, o_vld, e_vld); end
         total++;
         if (o_aout !== e_aout) begin bad++; $display("FAIL rand_aout: cycle %0d aout=%b required %b", k, o_aout, e_aout); end
         total++;
         if (o_is !== e_is) begin bad++; $display("FAIL rand_is: cycle %0d is=%b required %b", k, o_is, e_is); end
         total++;
         if (o_ack !== e_ack) begin bad++; $display("FAIL rand_ack: cycle %0d ack=%b required %b", k, o_ack, e_ack); end
      end
      rst_n = 1; en = 0; fcw_ld = 0;
   endtask

   initial begin
      rst_n = 0; en = 0; fcw_ld = 0; fcw = '0; phs = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_first_frames();
      test_quadrants();
      test_wrap();
      test_handshake();
      test_pause();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
